defuzz_div: RTL

- Sequential centroid divider: consumes the weighted-sum pair (S_w, S_wg) produced by the rule aggregator and computes the crisp controller output y = S_wg / S_w.
- Result is unsigned Q1.15, where 32768 = 1.0 = 100 %.
- Implemented as a radix-2 restoring divider, one quotient bit per clock, with valid/ready handshakes on both sides.
- Sits between the aggregator and the output/PWM scaling stage.

---
 rtl/defuzz_div.sv | 126 ++++++++++++
 1 files changed

// File: rtl/defuzz_div.sv
// Centroid divider: y = s_wg / s_w as unsigned Q1.15, radix-2 restoring, one quotient bit per cycle.
// Latency DW+1 edges from accept to first out_valid sample (2 for s_w == 0); result held under out_ready backpressure.
module defuzz_div #(
  parameter int W    = 16,
  parameter int FRAC = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s_w,
  input  logic [W-1:0] s_wg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         div0,
  output logic         sat
);

  localparam int DW = W + FRAC;
  localparam int CW = $clog2(DW + 1);
  localparam logic [DW-1:0] ONE_Q = DW'(1) << FRAC;
  localparam logic [W-1:0]  ONE_Y = ONE_Q[W-1:0];

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  divisor;
  logic [DW-1:0] dividend;
  logic [DW-1:0] quo;
  logic [W:0]    rem;
  logic [CW-1:0] count;

  logic [W:0]    rem_sh;
  logic [W:0]    rem_nxt;
  logic          q_bit;
  logic [DW-1:0] quo_nxt;
  logic          last_step;

  // rem < divisor always holds between steps, so dropping rem[W] on the shift loses nothing
  always_comb begin
    rem_sh    = {rem[W-1:0], dividend[DW-1]};
    q_bit     = (rem_sh >= {1'b0, divisor});
    rem_nxt   = q_bit ? (rem_sh - {1'b0, divisor}) : rem_sh;
    quo_nxt   = {quo[DW-2:0], q_bit};
    last_step = (count == CW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = DIV;
      end
      DIV: begin
        if ((divisor == '0) || last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor  <= '0;
      dividend <= '0;
      quo      <= '0;
      rem      <= '0;
      count    <= '0;
      y        <= '0;
      div0     <= 1'b0;
      sat      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            divisor  <= s_w;
            dividend <= {s_wg, {FRAC{1'b0}}};
            quo      <= '0;
            rem      <= '0;
            count    <= CW'(DW);
          end
        end
        DIV: begin
          if (divisor == '0) begin
            y    <= '0;
            div0 <= 1'b1;
            sat  <= 1'b0;
          end else begin
            rem      <= rem_nxt;
            dividend <= dividend << 1;
            quo      <= quo_nxt;
            count    <= count - CW'(1);
            // Final bit: clamp anything above 1.0 (upstream wrap or gains over 100 %)
            if (last_step) begin
              div0 <= 1'b0;
              if (quo_nxt > ONE_Q) begin
                y   <= ONE_Y;
                sat <= 1'b1;
              end else begin
                y   <= quo_nxt[W-1:0];
                sat <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
